// File: rtl/tlc_pkg.sv
// tlc_pkg
// Shared types and helpers for the traffic-light phase controller.
//   tlc_state_e : controller state encoding (codes are visible on the ST port)
//   ph_width()  : width of the phase index for a given phase count
//   params_ok() : legality check for the controller parameter set
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_ARED   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_EMERG  = 2'd3
    } tlc_state_e;

    localparam int NPH_DEF = 4;
    localparam int PH_W_DEF = $clog2(NPH_DEF);

    function automatic int ph_width(input int nph);
        return (nph <= 2) ? 1 : $clog2(nph);
    endfunction

    // The cycle counter must hold every terminal value without wrapping.
    function automatic bit params_ok(input int nph, input int cw, input int gmin,
                                     input int gmax, input int yel, input int ard);
        longint cnt_range;
        cnt_range = longint'(1) << cw;
        return (nph >= 2) && (nph <= 16) && (cw >= 1) && (cw <= 31) &&
               (gmin >= 1) && (gmin <= gmax) && (longint'(gmax) <= cnt_range) &&
               (yel >= 1) && (longint'(yel) <= cnt_range) &&
               (ard >= 1) && (longint'(ard) <= cnt_range);
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick
// Combinational round-robin phase picker. Scans phases ph+1 .. ph+NPH
// (mod NPH) and returns the first one with demand; the current phase is
// considered last so a lone requester can be re-served.
//   req   in  NPH  per-phase demand
//   ph    in  PW   current / last-served phase
//   pick  out PW   selected phase (ph when nothing is requested)
//   valid out 1    at least one request bit is set
module tlc_rr_pick
    import tlc_pkg::*;
#(
    parameter int NPH = 4,
    parameter int PW  = 2
) (
    input  logic [NPH-1:0] req,
    input  logic [PW-1:0]  ph,
    output logic [PW-1:0]  pick,
    output logic           valid
);

    logic [31:0] idx;

    // Walk from the farthest candidate down to the nearest so the nearest
    // requesting phase wins the final assignment.
    always_comb begin
        pick  = ph;
        valid = 1'b0;
        idx   = '0;
        for (int i = NPH; i >= 1; i--) begin
            idx = (32'(ph) + 32'(i)) % 32'(NPH);
            if (req[idx[PW-1:0]]) begin
                pick  = idx[PW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_phase_ctrl.sv
// tlc_phase_ctrl
// Multi-phase traffic-light phase controller: demand-driven round-robin
// green/yellow/all-red sequencing with minimum/maximum green, emergency
// preemption and synchronous clear. REQ and EMG are registered once before
// use, so an input change is seen on ST/lamps one edge after it is sampled.
//   CK  in  1          clock, rising edge
//   RN  in  1          asynchronous active-low reset
//   CLR in  1          synchronous clear (same result as reset)
//   REQ in  NPH        per-phase demand
//   EMG in  1          emergency preempt, level
//   GRN out NPH        green lamps, one-hot or zero
//   YLW out NPH        yellow lamps, one-hot or zero
//   PH  out PW         current / last-served phase
//   ST  out 2          state code
//   CNT out CW         cycles elapsed in current state
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARED   | all-red clearance; rests here (CNT=ARD-1) with no demand
// ST_GREEN  | GRN[PH] lit; min green guaranteed, max green enforced
// ST_YELLOW | YLW[PH] lit for YEL cycles
// ST_EMERG  | emergency preempt, all lamps off until EMG drops
module tlc_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int NPH  = 4,
    parameter int CW   = 6,
    parameter int GMIN = 8,
    parameter int GMAX = 32,
    parameter int YEL  = 3,
    parameter int ARD  = 2,
    localparam int PW  = ph_width(NPH)
) (
    input  logic           CK,
    input  logic           RN,
    input  logic           CLR,
    input  logic [NPH-1:0] REQ,
    input  logic           EMG,
    output logic [NPH-1:0] GRN,
    output logic [NPH-1:0] YLW,
    output logic [PW-1:0]  PH,
    output logic [1:0]     ST,
    output logic [CW-1:0]  CNT
);

    if (!params_ok(NPH, CW, GMIN, GMAX, YEL, ARD)) begin : g_param_err
        $error("tlc_phase_ctrl: illegal parameter set");
    end

    localparam logic [CW-1:0]  CNT_ARD  = CW'(ARD - 1);
    localparam logic [CW-1:0]  CNT_YEL  = CW'(YEL - 1);
    localparam logic [CW-1:0]  CNT_GMIN = CW'(GMIN - 1);
    localparam logic [CW-1:0]  CNT_GMAX = CW'(GMAX - 1);
    localparam logic [NPH-1:0] ONE_HOT0 = NPH'(1);

    tlc_state_e     st_q, st_d;
    logic [PW-1:0]  ph_q, ph_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [NPH-1:0] grn_q, grn_d, ylw_q, ylw_d;
    logic [NPH-1:0] req_q;
    logic           emg_q;
    logic [NPH-1:0] other_req;
    logic [PW-1:0]  pick;
    logic           pick_vld;

    tlc_rr_pick #(
        .NPH (NPH),
        .PW  (PW)
    ) u_pick (
        .req   (req_q),
        .ph    (ph_q),
        .pick  (pick),
        .valid (pick_vld)
    );

    assign other_req = req_q & ~(ONE_HOT0 << ph_q);

    // Saturate so EMERG dwell cannot wrap the counter.
    assign cnt_inc = (cnt_q == CNT_GMAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        st_d  = st_q;
        ph_d  = ph_q;
        cnt_d = cnt_inc;
        unique case (st_q)
            ST_ARED: begin
                if (emg_q) begin
                    st_d  = ST_EMERG;
                    cnt_d = '0;
                end else if (cnt_q == CNT_ARD) begin
                    if (pick_vld) begin
                        st_d  = ST_GREEN;
                        ph_d  = pick;
                        cnt_d = '0;
                    end else begin
                        cnt_d = CNT_ARD;
                    end
                end
            end
            ST_GREEN: begin
                if (((emg_q || (|other_req)) && (cnt_q >= CNT_GMIN)) ||
                    (cnt_q == CNT_GMAX)) begin
                    st_d  = ST_YELLOW;
                    cnt_d = '0;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == CNT_YEL) begin
                    st_d  = emg_q ? ST_EMERG : ST_ARED;
                    cnt_d = '0;
                end
            end
            ST_EMERG: begin
                if (!emg_q) begin
                    st_d  = ST_ARED;
                    cnt_d = '0;
                end
            end
            default: begin
                st_d  = ST_ARED;
                cnt_d = '0;
            end
        endcase
    end

    // Lamps are decoded from the next state so they leave the flops
    // aligned with ST and PH.
    always_comb begin
        grn_d = '0;
        ylw_d = '0;
        if (st_d == ST_GREEN)  grn_d = ONE_HOT0 << ph_d;
        if (st_d == ST_YELLOW) ylw_d = ONE_HOT0 << ph_d;
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            st_q  <= ST_ARED;
            ph_q  <= '0;
            cnt_q <= '0;
            grn_q <= '0;
            ylw_q <= '0;
            req_q <= '0;
            emg_q <= 1'b0;
        end else if (CLR) begin
            st_q  <= ST_ARED;
            ph_q  <= '0;
            cnt_q <= '0;
            grn_q <= '0;
            ylw_q <= '0;
            req_q <= '0;
            emg_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            grn_q <= grn_d;
            ylw_q <= ylw_d;
            req_q <= REQ;
            emg_q <= EMG;
        end
    end

    assign GRN = grn_q;
    assign YLW = ylw_q;
    assign PH  = ph_q;
    assign ST  = st_q;
    assign CNT = cnt_q;

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// tb_tlc_phase_ctrl
// Directed-vector bench for tlc_phase_ctrl with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tlc_phase_ctrl;

    logic       CK;
    logic       RN;
    logic       CLR;
    logic [3:0] REQ;
    logic       EMG;
    logic [3:0] GRN;
    logic [3:0] YLW;
    logic [1:0] PH;
    logic [1:0] ST;
    logic [5:0] CNT;

    int n_chk;
    int n_err;

    tlc_phase_ctrl dut (
        .CK  (CK),
        .RN  (RN),
        .CLR (CLR),
        .REQ (REQ),
        .EMG (EMG),
        .GRN (GRN),
        .YLW (YLW),
        .PH  (PH),
        .ST  (ST),
        .CNT (CNT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CK);
    endtask

    // Holds reset across one rising edge, then releases on a falling edge
    // so the next rising edge is edge 1 of the scenario.
    task automatic do_reset(input logic [3:0] req_v);
        RN  = 1'b0;
        CLR = 1'b0;
        EMG = 1'b0;
        REQ = req_v;
        step(1);
        RN = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        RN  = 1'b0;
        CLR = 1'b0;
        EMG = 1'b0;
        REQ = 4'b0000;
        step(2);
        chk("rst_st",  32'(ST),  0);
        chk("rst_ph",  32'(PH),  0);
        chk("rst_cnt", 32'(CNT), 0);
        chk("rst_grn", 32'(GRN), 0);
        chk("rst_ylw", 32'(YLW), 0);

        // Single requester: max green, yellow, all-red, re-served.
        do_reset(4'b0100);
        step(1);
        chk("s1_e1_st",  32'(ST),  0);
        chk("s1_e1_cnt", 32'(CNT), 1);
        chk("s1_e1_grn", 32'(GRN), 0);
        step(1);
        chk("s1_e2_grn", 32'(GRN), 32'b0100);
        chk("s1_e2_st",  32'(ST),  1);
        chk("s1_e2_ph",  32'(PH),  2);
        chk("s1_e2_cnt", 32'(CNT), 0);
        step(31);
        chk("s1_e33_grn", 32'(GRN), 32'b0100);
        chk("s1_e33_cnt", 32'(CNT), 31);
        step(1);
        chk("s1_e34_ylw", 32'(YLW), 32'b0100);
        chk("s1_e34_grn", 32'(GRN), 0);
        chk("s1_e34_st",  32'(ST),  2);
        step(2);
        chk("s1_e36_ylw", 32'(YLW), 32'b0100);
        chk("s1_e36_cnt", 32'(CNT), 2);
        step(1);
        chk("s1_e37_st",  32'(ST),  0);
        chk("s1_e37_ylw", 32'(YLW), 0);
        chk("s1_e37_cnt", 32'(CNT), 0);
        step(1);
        chk("s1_e38_cnt", 32'(CNT), 1);
        chk("s1_e38_grn", 32'(GRN), 0);
        step(1);
        chk("s1_e39_grn", 32'(GRN), 32'b0100);
        chk("s1_e39_ph",  32'(PH),  2);

        // Competing demand ends green at minimum, then round-robin to phase 2.
        do_reset(4'b0001);
        step(2);
        chk("s2_e2_grn", 32'(GRN), 32'b0001);
        chk("s2_e2_ph",  32'(PH),  0);
        REQ = 4'b0101;
        step(7);
        chk("s2_e9_grn", 32'(GRN), 32'b0001);
        chk("s2_e9_cnt", 32'(CNT), 7);
        step(1);
        chk("s2_e10_ylw", 32'(YLW), 32'b0001);
        chk("s2_e10_grn", 32'(GRN), 0);
        chk("s2_e10_ph",  32'(PH),  0);
        step(3);
        chk("s2_e13_st",  32'(ST),  0);
        chk("s2_e13_cnt", 32'(CNT), 0);
        step(1);
        chk("s2_e14_grn", 32'(GRN), 0);
        step(1);
        chk("s2_e15_grn", 32'(GRN), 32'b0100);
        chk("s2_e15_ph",  32'(PH),  2);

        // No demand: rest in red, then a request is served two edges later.
        do_reset(4'b0000);
        step(5);
        chk("s3_rest_st",  32'(ST),  0);
        chk("s3_rest_cnt", 32'(CNT), 1);
        chk("s3_rest_grn", 32'(GRN), 0);
        REQ = 4'b0010;
        step(1);
        chk("s3_e6_grn", 32'(GRN), 0);
        chk("s3_e6_st",  32'(ST),  0);
        step(1);
        chk("s3_e7_grn", 32'(GRN), 32'b0010);
        chk("s3_e7_ph",  32'(PH),  1);

        // Emergency during green: min green kept, yellow, EMERG, recovery.
        do_reset(4'b0001);
        step(5);
        chk("s4_e5_cnt", 32'(CNT), 3);
        chk("s4_e5_st",  32'(ST),  1);
        EMG = 1'b1;
        step(4);
        chk("s4_e9_grn", 32'(GRN), 32'b0001);
        chk("s4_e9_cnt", 32'(CNT), 7);
        step(1);
        chk("s4_e10_st",  32'(ST),  2);
        chk("s4_e10_ylw", 32'(YLW), 32'b0001);
        step(2);
        chk("s4_e12_st", 32'(ST), 2);
        step(1);
        chk("s4_e13_st",  32'(ST),  3);
        chk("s4_e13_grn", 32'(GRN), 0);
        chk("s4_e13_ylw", 32'(YLW), 0);
        step(2);
        EMG = 1'b0;
        step(1);
        chk("s4_e16_st", 32'(ST), 3);
        step(1);
        chk("s4_e17_st",  32'(ST),  0);
        chk("s4_e17_cnt", 32'(CNT), 0);
        chk("s4_e17_ph",  32'(PH),  0);
        step(1);
        chk("s4_e18_st", 32'(ST), 0);
        step(1);
        chk("s4_e19_st",  32'(ST),  1);
        chk("s4_e19_grn", 32'(GRN), 32'b0001);

        // Emergency while resting in red preempts without waiting.
        do_reset(4'b0000);
        step(3);
        EMG = 1'b1;
        step(1);
        chk("s5_emg_lat_st", 32'(ST), 0);
        step(1);
        chk("s5_emg_st", 32'(ST), 3);
        EMG = 1'b0;
        step(2);
        chk("s5_rec_st",  32'(ST),  0);
        chk("s5_rec_cnt", 32'(CNT), 0);

        // Synchronous clear mid-yellow, then asynchronous reset mid-green.
        do_reset(4'b0100);
        step(35);
        chk("s6_e35_ylw", 32'(YLW), 32'b0100);
        chk("s6_e35_ph",  32'(PH),  2);
        chk("s6_e35_cnt", 32'(CNT), 1);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        chk("s6_clr_st",  32'(ST),  0);
        chk("s6_clr_ph",  32'(PH),  0);
        chk("s6_clr_cnt", 32'(CNT), 0);
        chk("s6_clr_ylw", 32'(YLW), 0);
        step(2);
        chk("s6_regrn", 32'(GRN), 32'b0100);
        step(3);
        chk("s6_pre_rn_grn", 32'(GRN), 32'b0100);
        RN = 1'b0;
        #1;
        chk("s6_rn_grn", 32'(GRN), 0);
        chk("s6_rn_st",  32'(ST),  0);
        step(1);
        RN = 1'b1;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
